tsc_multicycle_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle TSC cpu.
- Fetches instructions over a valid/ready instruction-memory port and sequences each through FETCH/DECODE/EXEC/WB.
- Holds a 4-entry register file and drives output_port (WWD or register_selection view), PC_below8bit and num_inst.
- Sits between the instruction memory/ROM and output_logic.

---
 rtl/tsc_multicycle_core.sv | 200 ++++++++++++++++++++
 tb/tb_tsc_multicycle_core.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsc_multicycle_core.sv
// tsc_multicycle_core: multi-cycle TSC cpu with valid/ready fetch.
// FETCH/DECODE/EXEC/WB sequencing, 4-entry regfile, WWD output latch.
module tsc_multicycle_core #(
  parameter int WORD_SIZE     = 16,
  parameter int PC_SIZE       = 8,
  parameter int NUM_INST_SIZE = 16
) (
  input  logic                     clk,
  input  logic                     reset_cpu,
  input  logic                     cpu_enable,
  input  logic                     wwd_enable,
  input  logic [1:0]               register_selection,
  output logic                     imem_req,
  output logic [PC_SIZE-1:0]       imem_addr,
  input  logic                     imem_ready,
  input  logic [15:0]              imem_data,
  output logic [NUM_INST_SIZE-1:0] num_inst,
  output logic [WORD_SIZE-1:0]     output_port,
  output logic [7:0]               PC_below8bit
);

  localparam logic [3:0] OP_R   = 4'd15;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd9;

  localparam logic [5:0] F_ADD = 6'd0;
  localparam logic [5:0] F_SUB = 6'd1;
  localparam logic [5:0] F_AND = 6'd2;
  localparam logic [5:0] F_ORR = 6'd3;
  localparam logic [5:0] F_WWD = 6'd28;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t state;

  logic [PC_SIZE-1:0]   pc;
  logic [15:0]          ir;
  logic [WORD_SIZE-1:0] rf [4];
  logic [WORD_SIZE-1:0] a_q;
  logic [WORD_SIZE-1:0] b_q;
  logic [WORD_SIZE-1:0] alu_q;
  logic                 wen_q;
  logic [1:0]           dst_q;
  logic                 wwd_q;
  logic [PC_SIZE-1:0]   npc_q;
  logic [WORD_SIZE-1:0] wwd_latch;

  logic [3:0]  op;
  logic [1:0]  rs;
  logic [1:0]  rt;
  logic [1:0]  rd;
  logic [5:0]  func;
  logic [7:0]  imm;
  logic [11:0] target;
  logic        is_r;

  assign op     = ir[15:12];
  assign rs     = ir[11:10];
  assign rt     = ir[9:8];
  assign rd     = ir[7:6];
  assign func   = ir[5:0];
  assign imm    = ir[7:0];
  assign target = ir[11:0];
  assign is_r   = (op == OP_R);

  logic [WORD_SIZE-1:0] alu_d;
  logic                 wen_d;
  logic [1:0]           dst_d;
  logic                 wwd_d;
  logic [PC_SIZE-1:0]   npc_d;

  // Decode IR against latched operands into result, dest and next PC
  always_comb begin
    alu_d = '0;
    wen_d = 1'b0;
    dst_d = rt;
    wwd_d = 1'b0;
    npc_d = pc + PC_SIZE'(1);
    unique case (1'b1)
      is_r && (func == F_ADD): begin
        alu_d = a_q + b_q;
        wen_d = 1'b1;
        dst_d = rd;
      end
      is_r && (func == F_SUB): begin
        alu_d = a_q - b_q;
        wen_d = 1'b1;
        dst_d = rd;
      end
      is_r && (func == F_AND): begin
        alu_d = a_q & b_q;
        wen_d = 1'b1;
        dst_d = rd;
      end
      is_r && (func == F_ORR): begin
        alu_d = a_q | b_q;
        wen_d = 1'b1;
        dst_d = rd;
      end
      is_r && (func == F_WWD): begin
        wwd_d = 1'b1;
      end
      op == OP_ADI: begin
        alu_d = a_q + WORD_SIZE'($signed(imm));
        wen_d = 1'b1;
      end
      op == OP_ORI: begin
        alu_d = a_q | WORD_SIZE'(imm);
        wen_d = 1'b1;
      end
      op == OP_LHI: begin
        alu_d = WORD_SIZE'({imm, 8'h00});
        wen_d = 1'b1;
      end
      op == OP_JMP: begin
        npc_d = PC_SIZE'(target);
      end
      default: ;
    endcase
  end

  // Sequencer: fetch handshake, IR, PC and retire counter
  always_ff @(posedge clk or negedge reset_cpu) begin
    if (!reset_cpu) begin
      state    <= S_FETCH;
      imem_req <= 1'b0;
      ir       <= '0;
      pc       <= '0;
      num_inst <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_req && imem_ready) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else if (cpu_enable) begin
            imem_req <= 1'b1;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC:   state <= S_WB;
        S_WB: begin
          pc       <= npc_q;
          num_inst <= num_inst + NUM_INST_SIZE'(1);
          imem_req <= cpu_enable;
          state    <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Datapath: operand latches, EXEC results, regfile and WWD writes
  always_ff @(posedge clk or negedge reset_cpu) begin
    if (!reset_cpu) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      wen_q     <= 1'b0;
      dst_q     <= '0;
      wwd_q     <= 1'b0;
      npc_q     <= '0;
      wwd_latch <= '0;
    end else begin
      unique case (state)
        S_DECODE: begin
          a_q <= rf[rs];
          b_q <= rf[rt];
        end
        S_EXEC: begin
          alu_q <= alu_d;
          wen_q <= wen_d;
          dst_q <= dst_d;
          wwd_q <= wwd_d;
          npc_q <= npc_d;
        end
        S_WB: begin
          if (wen_q) rf[dst_q] <= alu_q;
          if (wwd_q && wwd_enable) wwd_latch <= a_q;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr    = pc;
  assign PC_below8bit = pc[7:0];
  assign output_port  = wwd_enable ? wwd_latch
                                   : rf[register_selection];

endmodule

// File: tb/tb_tsc_multicycle_core.sv
// tb_tsc_multicycle_core: directed bench for the multi-cycle TSC core.
// Memory model serves a program array; checks are immediate assertions.
module tb_tsc_multicycle_core;

  logic        clk;
  logic        reset_cpu;
  logic        cpu_enable;
  logic        wwd_enable;
  logic [1:0]  register_selection;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic [15:0] num_inst;
  logic [15:0] output_port;
  logic [7:0]  PC_below8bit;

  logic [15:0] mem [256];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  logic [15:0] prog [24] = '{
    16'h6000, 16'h6101, 16'h6202, 16'h6303,
    16'hf01c, 16'hf41c, 16'hf81c, 16'hfc1c,
    16'h4204, 16'h47fc, 16'hf81c, 16'hfc1c,
    16'hf6c0, 16'hf180, 16'hf81c, 16'hfc1c,
    16'h9015,
    16'h6000, 16'h4000, 16'hfd80,
    16'hf01c, 16'hf41c, 16'hf81c, 16'hfc1c
  };

  logic [15:0] exp_out [24] = '{
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0100, 16'h0200, 16'h0300,
    16'h0300, 16'h0300, 16'h0004, 16'h00fc,
    16'h00fc, 16'h00fc, 16'h0100, 16'h0104,
    16'h0104,
    16'h0104, 16'h0104, 16'h0104,
    16'h0000, 16'h0100, 16'h0204, 16'h0104
  };

  logic [15:0] exp_rf [4] = '{
    16'h0000, 16'h0100, 16'h0204, 16'h0104
  };

  assign imem_data = mem[imem_addr];

  tsc_multicycle_core #(
    .WORD_SIZE(16),
    .PC_SIZE(8),
    .NUM_INST_SIZE(16)
  ) dut (
    .clk(clk),
    .reset_cpu(reset_cpu),
    .cpu_enable(cpu_enable),
    .wwd_enable(wwd_enable),
    .register_selection(register_selection),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_data(imem_data),
    .num_inst(num_inst),
    .output_port(output_port),
    .PC_below8bit(PC_below8bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_cpu = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_cpu = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic run_instr(input int waits,
                           input logic [7:0] exp_pc,
                           output int c);
    logic [15:0] n0;
    c = 0;
    imem_ready = (waits == 0);
    while (!imem_req && c < 20) begin
      @(posedge clk); #1; c++;
    end
    chk("req", {31'd0, imem_req}, 1);
    chk("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
    n0 = num_inst;
    for (int w = 0; w < waits; w++) begin
      @(posedge clk); #1; c++;
      chk("wait_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
    end
    imem_ready = 1'b1;
    @(posedge clk); #1; c++;
    if (waits > 0) imem_ready = 1'b0;
    while (num_inst == n0 && c < 40) begin
      @(posedge clk); #1; c++;
    end
    chk("retire", {16'd0, num_inst}, {16'd0, n0 + 16'd1});
  endtask

  initial begin
    logic [15:0] n0;
    reset_cpu = 1'b0;
    cpu_enable = 1'b1;
    wwd_enable = 1'b1;
    register_selection = 2'd0;
    imem_ready = 1'b0;
    clear_mem();
    for (int i = 0; i < 17; i++) mem[i] = prog[i];
    for (int i = 17; i < 24; i++) mem[i + 4] = prog[i];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_num", {16'd0, num_inst}, 0);
    chk("rst_out", {16'd0, output_port}, 0);
    chk("rst_pc8", {24'd0, PC_below8bit}, 0);
    chk("rst_addr", {24'd0, imem_addr}, 0);
    reset_cpu = 1'b1;
    @(posedge clk); #1;
    chk("rel_req", {31'd0, imem_req}, 1);
    chk("rel_addr", {24'd0, imem_addr}, 0);

    for (int i = 0; i < 24; i++) begin
      run_instr(0, 8'(i < 17 ? i : i + 4), cyc);
      chk("legacy_wwd", {16'd0, output_port}, {16'd0, exp_out[i]});
      if (i > 0) chk("lat4", cyc, 4);
    end
    chk("legacy_num", {16'd0, num_inst}, 24);
    chk("legacy_pc8", {24'd0, PC_below8bit}, 8'h1c);
    wwd_enable = 1'b0;
    for (int s = 0; s < 4; s++) begin
      register_selection = 2'(s);
      #1;
      chk("legacy_rf", {16'd0, output_port}, {16'd0, exp_rf[s]});
    end
    wwd_enable = 1'b1;
    #1;
    chk("legacy_latch", {16'd0, output_port}, 16'h0104);

    imem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_instr(3, 8'(i), cyc);
      chk("ws_wwd", {16'd0, output_port}, {16'd0, exp_out[i]});
      if (i > 0) chk("lat7", cyc, 7);
    end

    clear_mem();
    mem[0] = 16'h6101;
    mem[1] = 16'hf41c;
    mem[2] = 16'h6202;
    mem[3] = 16'hf81c;
    imem_ready = 1'b0;
    do_reset();
    run_instr(0, 8'd0, cyc);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    cpu_enable = 1'b0;
    n0 = num_inst;
    for (int k = 0; k < 10 && num_inst == n0; k++) begin
      @(posedge clk); #1;
    end
    chk("halt_retire", {16'd0, num_inst}, 2);
    chk("halt_wwd", {16'd0, output_port}, 16'h0100);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("halt_req", {31'd0, imem_req}, 0);
    end
    chk("halt_num", {16'd0, num_inst}, 2);
    chk("halt_addr", {24'd0, imem_addr}, 2);
    cpu_enable = 1'b1;
    run_instr(0, 8'd2, cyc);
    chk("resume_num", {16'd0, num_inst}, 3);
    imem_ready = 1'b0;
    cpu_enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("hold_req", {31'd0, imem_req}, 1);
      chk("hold_addr", {24'd0, imem_addr}, 3);
    end
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    n0 = num_inst;
    for (int k = 0; k < 10 && num_inst == n0; k++) begin
      @(posedge clk); #1;
    end
    chk("hold_num", {16'd0, num_inst}, 4);
    chk("hold_wwd", {16'd0, output_port}, 16'h0200);
    @(posedge clk); #1;
    chk("idle_req", {31'd0, imem_req}, 0);

    clear_mem();
    mem[0]   = 16'h6212;
    mem[1]   = 16'hf01c;
    mem[2]   = 16'h5101;
    mem[3]   = 16'hf1c1;
    mem[4]   = 16'h2abc;
    mem[5]   = 16'hfe02;
    mem[6]   = 16'hf643;
    mem[7]   = 16'h90ff;
    mem[255] = 16'h40ff;
    cpu_enable = 1'b1;
    wwd_enable = 1'b0;
    register_selection = 2'd2;
    imem_ready = 1'b0;
    do_reset();
    run_instr(0, 8'd0, cyc);
    chk("lhi_view", {16'd0, output_port}, 16'h1200);
    run_instr(0, 8'd1, cyc);
    chk("wwd_off_view", {16'd0, output_port}, 16'h1200);
    wwd_enable = 1'b1;
    #1;
    chk("wwd_off_latch", {16'd0, output_port}, 16'h0000);
    wwd_enable = 1'b0;
    register_selection = 2'd1;
    run_instr(0, 8'd2, cyc);
    chk("ori", {16'd0, output_port}, 16'h0001);
    register_selection = 2'd3;
    run_instr(0, 8'd3, cyc);
    chk("sub_wrap", {16'd0, output_port}, 16'hffff);
    run_instr(0, 8'd4, cyc);
    chk("nop_num", {16'd0, num_inst}, 5);
    chk("nop_rf", {16'd0, output_port}, 16'hffff);
    chk("nop_pc", {24'd0, imem_addr}, 5);
    register_selection = 2'd0;
    run_instr(0, 8'd5, cyc);
    chk("and", {16'd0, output_port}, 16'h1200);
    register_selection = 2'd1;
    run_instr(0, 8'd6, cyc);
    chk("orr", {16'd0, output_port}, 16'h1201);
    run_instr(0, 8'd7, cyc);
    chk("jmp_addr", {24'd0, imem_addr}, 8'hff);
    chk("jmp_pc8", {24'd0, PC_below8bit}, 8'hff);
    register_selection = 2'd0;
    run_instr(0, 8'hff, cyc);
    chk("pc_wrap", {24'd0, imem_addr}, 0);
    chk("pc_wrap8", {24'd0, PC_below8bit}, 0);
    chk("adi_neg", {16'd0, output_port}, 16'h11ff);

    imem_ready = 1'b0;
    do_reset();
    register_selection = 2'd2;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_cpu = 1'b0;
    #1;
    chk("arst_num", {16'd0, num_inst}, 0);
    chk("arst_req", {31'd0, imem_req}, 0);
    chk("arst_view", {16'd0, output_port}, 0);
    cpu_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_cpu = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("arst_nowb", {16'd0, output_port}, 0);
    chk("arst_nocnt", {16'd0, num_inst}, 0);
    chk("arst_idle", {31'd0, imem_req}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
